// File: rtl/obstacle_swap_ctrl.sv
// Double-buffered obstacle/aux frame-swap controller between game logic and VGA.
// Latency: 1-cycle registered front-bank read; swap at the next vsync start, then N_SLOTS-cycle re-seed.
// Backpressure: ready low in PENDING/COPY; writes and commits are dropped while ready is low.
//
// Ports: clk/rst (sync, active-high); vs (active-low vsync); back-bank write port
// (wr_en/wr_idx/wr_slot, aux_wr_en/aux_wr); commit/pending/commit_done/ready handshake;
// front-bank read port (rd_idx -> rd_slot/rd_aux); frame_cnt/swap_cnt statistics.
// Build option: define OBSTACLE_SWAP_STATS_EN to enable the saturating frame/swap counters;
// otherwise both counter outputs are tied to zero.
module obstacle_swap_ctrl #(
    parameter int N_SLOTS = 10,
    parameter int IDX_W   = 4,
    parameter int SLOT_W  = 38,
    parameter int AUX_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vs,
    output logic              ready,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic              aux_wr_en,
    input  logic [AUX_W-1:0]  aux_wr,
    input  logic              commit,
    output logic              pending,
    output logic              commit_done,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [SLOT_W-1:0] rd_slot,
    output logic [AUX_W-1:0]  rd_aux,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       swap_cnt
);

    // Off-screen obstacle: {x_left, x_right, y_up, y_down}
    localparam logic [SLOT_W-1:0] SLOT_RST = {10'd700, 10'd700, 9'd500, 9'd500};
    // {player_y, gamemode}
    localparam logic [AUX_W-1:0]  AUX_RST  = {9'd240, 2'b00};
    localparam logic [IDX_W:0]    N_LIM    = (IDX_W+1)'(N_SLOTS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_SLOTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_COPY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              done_nxt;
    logic              vs_q;
    logic              frame_edge;
    logic              bank_sel;
    logic              back_sel;
    logic [IDX_W-1:0]  copy_idx;
    logic [SLOT_W-1:0] bank [2][N_SLOTS];
    logic [AUX_W-1:0]  aux  [2];

    // First cycle of the (active-low) sync pulse
    assign frame_edge = vs_q & ~vs;
    assign back_sel   = ~bank_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            commit_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            commit_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        ready     = 1'b0;
        pending   = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                // An edge coinciding with the commit is deliberately not used
                if (commit) state_nxt = ST_PENDING;
            end
            ST_PENDING: begin
                pending = 1'b1;
                if (frame_edge) state_nxt = ST_COPY;
            end
            ST_COPY: begin
                if (copy_idx == LAST_IDX) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N_SLOTS; i++) bank[b][i] <= SLOT_RST;
                aux[b] <= AUX_RST;
            end
            vs_q     <= 1'b1;
            bank_sel <= 1'b0;
            copy_idx <= '0;
            rd_slot  <= SLOT_RST;
            rd_aux   <= AUX_RST;
        end else begin
            vs_q <= vs;
            case (state)
                ST_IDLE: begin
                    if (wr_en && ({1'b0, wr_idx} < N_LIM)) bank[back_sel][wr_idx] <= wr_slot;
                    if (aux_wr_en) aux[back_sel] <= aux_wr;
                end
                ST_PENDING: begin
                    if (frame_edge) begin
                        bank_sel <= ~bank_sel;
                        copy_idx <= '0;
                    end
                end
                ST_COPY: begin
                    // Re-seed the new back bank so the next frame can be a partial update
                    bank[back_sel][copy_idx] <= bank[bank_sel][copy_idx];
                    if (copy_idx == '0) aux[back_sel] <= aux[bank_sel];
                    copy_idx <= copy_idx + 1'b1;
                end
                default: ;
            endcase
            rd_slot <= ({1'b0, rd_idx} < N_LIM) ? bank[bank_sel][rd_idx] : SLOT_RST;
            rd_aux  <= aux[bank_sel];
        end
    end

`ifdef OBSTACLE_SWAP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            swap_cnt  <= '0;
        end else begin
            if (frame_edge && (frame_cnt != 16'hFFFF)) frame_cnt <= frame_cnt + 16'd1;
            if ((state == ST_PENDING) && frame_edge && (swap_cnt != 16'hFFFF))
                swap_cnt <= swap_cnt + 16'd1;
        end
    end
`else
    assign frame_cnt = '0;
    assign swap_cnt  = '0;
`endif

endmodule

// File: tb/tb_obstacle_swap_ctrl.sv
// Directed bench for obstacle_swap_ctrl: reset, commit/swap timing, re-seed, ignored inputs, reset abort.
// Latency: expectations follow 1-cycle read latency and commit_done at edge+N_SLOTS+1.
// Backpressure: writes/commits issued while ready is low must have no effect.
module tb_obstacle_swap_ctrl;

    localparam int N_SLOTS = 10;
    localparam int IDX_W   = 4;
    localparam int SLOT_W  = 38;
    localparam int AUX_W   = 11;

`ifdef OBSTACLE_SWAP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [SLOT_W-1:0] SLOT_RST = {10'd700, 10'd700, 9'd500, 9'd500};
    localparam logic [AUX_W-1:0]  AUX_RST  = {9'd240, 2'b00};
    localparam logic [SLOT_W-1:0] S2       = {10'd100, 10'd140, 9'd50, 9'd120};
    localparam logic [SLOT_W-1:0] S5       = {10'd320, 10'd360, 9'd200, 9'd260};
    localparam logic [SLOT_W-1:0] JUNK     = {10'd1, 10'd2, 9'd3, 9'd4};
    localparam logic [AUX_W-1:0]  A1       = {9'd300, 2'b01};
    localparam logic [AUX_W-1:0]  A_JUNK   = {9'd17, 2'b11};

    logic              clk = 1'b0;
    logic              rst;
    logic              vs;
    logic              ready;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [SLOT_W-1:0] wr_slot;
    logic              aux_wr_en;
    logic [AUX_W-1:0]  aux_wr;
    logic              commit;
    logic              pending;
    logic              commit_done;
    logic [IDX_W-1:0]  rd_idx;
    logic [SLOT_W-1:0] rd_slot;
    logic [AUX_W-1:0]  rd_aux;
    logic [15:0]       frame_cnt;
    logic [15:0]       swap_cnt;

    int n_vec = 0;
    int n_err = 0;
    int off;

    obstacle_swap_ctrl #(
        .N_SLOTS(N_SLOTS), .IDX_W(IDX_W), .SLOT_W(SLOT_W), .AUX_W(AUX_W)
    ) dut (
        .clk(clk), .rst(rst), .vs(vs), .ready(ready),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_slot(wr_slot),
        .aux_wr_en(aux_wr_en), .aux_wr(aux_wr),
        .commit(commit), .pending(pending), .commit_done(commit_done),
        .rd_idx(rd_idx), .rd_slot(rd_slot), .rd_aux(rd_aux),
        .frame_cnt(frame_cnt), .swap_cnt(swap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle vsync low pulse; returns in the cycle after the edge cycle
    task automatic do_edge();
        vs = 1'b0;
        tick();
        vs = 1'b1;
    endtask

    // Counts cycles from the edge until commit_done, starting at offset start
    task automatic wait_done(input int start, output int o);
        o = start;
        while (!commit_done && o < 40) begin
            tick();
            o++;
        end
    endtask

    task automatic chk_stats(input string tag, input int frames, input int swaps);
        chk({tag, "_frame_cnt"}, 64'(frame_cnt), STATS ? 64'(frames) : 64'd0);
        chk({tag, "_swap_cnt"},  64'(swap_cnt),  STATS ? 64'(swaps)  : 64'd0);
    endtask

    initial begin
        rst = 1'b1; vs = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_slot = '0;
        aux_wr_en = 1'b0; aux_wr = '0; commit = 1'b0; rd_idx = 4'd3;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_rd_slot", 64'(rd_slot), 64'(SLOT_RST));
        chk("rst_rd_aux", 64'(rd_aux), 64'(AUX_RST));
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_done", 64'(commit_done), 64'd0);
        chk_stats("rst", 0, 0);

        // Write slot 2 + aux together with commit
        rd_idx = 4'd2;
        wr_en = 1'b1; wr_idx = 4'd2; wr_slot = S2;
        aux_wr_en = 1'b1; aux_wr = A1; commit = 1'b1;
        tick();
        wr_en = 1'b0; aux_wr_en = 1'b0; commit = 1'b0;
        chk("pend_enter", 64'(pending), 64'd1);
        chk("pend_ready", 64'(ready), 64'd0);

        // Writes and extra commits while pending must be dropped
        wr_en = 1'b1; wr_idx = 4'd0; wr_slot = JUNK;
        aux_wr_en = 1'b1; aux_wr = A_JUNK; commit = 1'b1;
        repeat (3) tick();
        wr_en = 1'b0; aux_wr_en = 1'b0; commit = 1'b0;
        repeat (96) tick();
        chk("hold_rd_slot2", 64'(rd_slot), 64'(SLOT_RST));
        chk("hold_rd_aux", 64'(rd_aux), 64'(AUX_RST));
        chk("hold_pending", 64'(pending), 64'd1);
        chk("hold_ready", 64'(ready), 64'd0);

        // Frame edge: swap, data visible from the cycle after the toggle
        do_edge();
        chk("copy_pending", 64'(pending), 64'd0);
        chk("copy_ready", 64'(ready), 64'd0);
        chk("copy_rd_old", 64'(rd_slot), 64'(SLOT_RST));
        tick();
        chk("swap_rd_slot2", 64'(rd_slot), 64'(S2));
        chk("swap_rd_aux", 64'(rd_aux), 64'(A1));
        wait_done(2, off);
        chk("done_offset1", 64'(off), 64'd11);
        chk("done_ready", 64'(ready), 64'd1);
        tick();
        chk("done_width", 64'(commit_done), 64'd0);
        rd_idx = 4'd0;
        tick();
        chk("pend_wr_dropped", 64'(rd_slot), 64'(SLOT_RST));
        chk_stats("swap1", 1, 1);

        // Edge while IDLE: no swap
        do_edge();
        tick();
        chk("idle_edge_pending", 64'(pending), 64'd0);
        chk("idle_edge_done", 64'(commit_done), 64'd0);

        // Out-of-range write, then partial update of slot 5
        wr_en = 1'b1; wr_idx = 4'd12; wr_slot = JUNK;
        tick();
        wr_idx = 4'd5; wr_slot = S5;
        tick();
        wr_en = 1'b0;

        // Commit coinciding with a frame edge: that edge is not used
        commit = 1'b1; vs = 1'b0;
        tick();
        commit = 1'b0; vs = 1'b1;
        repeat (5) tick();
        chk("same_edge_pending", 64'(pending), 64'd1);
        chk_stats("same_edge", 3, 1);

        do_edge();
        wait_done(1, off);
        chk("done_offset2", 64'(off), 64'd11);
        rd_idx = 4'd2;
        tick();
        chk("reseed_slot2", 64'(rd_slot), 64'(S2));
        chk("reseed_aux", 64'(rd_aux), 64'(A1));
        rd_idx = 4'd5;
        tick();
        chk("partial_slot5", 64'(rd_slot), 64'(S5));
        rd_idx = 4'd12;
        tick();
        chk("oob_rd", 64'(rd_slot), 64'(SLOT_RST));
        chk_stats("swap2", 4, 2);

        // Reset during COPY cycle 4 aborts everything
        rd_idx = 4'd5;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        do_edge();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("abort_rd_slot", 64'(rd_slot), 64'(SLOT_RST));
        chk("abort_rd_aux", 64'(rd_aux), 64'(AUX_RST));
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_pending", 64'(pending), 64'd0);
        chk("abort_done", 64'(commit_done), 64'd0);
        chk_stats("abort", 0, 0);
        rst = 1'b0;
        repeat (2) tick();
        chk("abort_bank_slot5", 64'(rd_slot), 64'(SLOT_RST));
        repeat (12) tick();
        chk("abort_no_done", 64'(commit_done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
